// File: rtl/thresh_pkg.sv
// Shared encodings for the parametrised thresholding core: operator modes and FSM states.
package thresh_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_BAND   = 2'd1,
        MODE_TRUNC  = 2'd2,
        MODE_TOZERO = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/thresh_pixel_op.sv
// Per-pixel threshold operator: maps one pixel to its output value and a pass flag
// according to the selected mode (all compares unsigned).
module thresh_pixel_op
    import thresh_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] pix_i,
    input  mode_t            mode_i,
    input  logic [PIX_W-1:0] th_lo_i,
    input  logic [PIX_W-1:0] th_hi_i,
    input  logic [PIX_W-1:0] hi_val_i,
    input  logic [PIX_W-1:0] lo_val_i,
    output logic [PIX_W-1:0] result_o,
    output logic             pass_o
);

    always_comb begin
        result_o = lo_val_i;
        pass_o   = 1'b0;
        case (mode_i)
            MODE_BINARY: begin
                pass_o   = (pix_i >= th_hi_i);
                result_o = pass_o ? hi_val_i : lo_val_i;
            end
            // An inverted band (ThLo > ThHi) can never pass, so it yields LoVal throughout.
            MODE_BAND: begin
                pass_o   = (pix_i >= th_lo_i) && (pix_i <= th_hi_i);
                result_o = pass_o ? hi_val_i : lo_val_i;
            end
            MODE_TRUNC: begin
                pass_o   = (pix_i > th_hi_i);
                result_o = pass_o ? th_hi_i : pix_i;
            end
            MODE_TOZERO: begin
                pass_o   = (pix_i >= th_hi_i);
                result_o = pass_o ? pix_i : '0;
            end
            default: begin
                pass_o   = 1'b0;
                result_o = lo_val_i;
            end
        endcase
    end

endmodule

// File: rtl/thresh_core_param.sv
// Thresholding core: reads packed source words, writes one thresholded pixel per cycle.
// Define THRESH_STATS_EN to build the HiCount pass counter; otherwise HiCount is tied to 0.
module thresh_core_param
    import thresh_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int NUM_PIX      = 76800,
    parameter int SRC_AW       = 15,
    parameter int DST_AW       = 17
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Go,
    output logic                          Done,
    output logic                          Busy,
    input  logic [1:0]                    Mode,
    input  logic [PIX_W-1:0]              ThLo,
    input  logic [PIX_W-1:0]              ThHi,
    input  logic [PIX_W-1:0]              HiVal,
    input  logic [PIX_W-1:0]              LoVal,
    output logic [SRC_AW-1:0]             Src_Addr,
    output logic                          Src_En,
    input  logic [PIX_W*PIX_PER_WORD-1:0] Src_Do,
    output logic [DST_AW-1:0]             Dst_Addr,
    output logic                          Dst_En,
    output logic                          Dst_We,
    output logic [PIX_W-1:0]              Dst_Di,
    output logic [DST_AW:0]               HiCount
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int KW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [DST_AW-1:0] LAST_PIX = DST_AW'(NUM_PIX - 1);
    localparam logic [KW-1:0]     LAST_K   = KW'(PIX_PER_WORD - 1);

    typedef struct packed {
        mode_t            mode;
        logic [PIX_W-1:0] th_lo;
        logic [PIX_W-1:0] th_hi;
        logic [PIX_W-1:0] hi_val;
        logic [PIX_W-1:0] lo_val;
    } cfg_t;

    state_t              state_q, state_d;
    cfg_t                cfg_q, cfg_d;
    logic [SRC_AW-1:0]   word_addr_q, word_addr_d;
    logic [DST_AW-1:0]   pix_addr_q, pix_addr_d;
    logic [KW-1:0]       k_q, k_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [PIX_W-1:0]    dst_di_q, dst_di_d;
    logic [PIX_W-1:0]    op_result;
    logic                op_pass;
    logic                go_accept;

    assign go_accept = Go && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // The unpack register shifts right after each write, so pixel k is always in the low slot.
    thresh_pixel_op #(.PIX_W(PIX_W)) u_op (
        .pix_i    (word_q[PIX_W-1:0]),
        .mode_i   (cfg_q.mode),
        .th_lo_i  (cfg_q.th_lo),
        .th_hi_i  (cfg_q.th_hi),
        .hi_val_i (cfg_q.hi_val),
        .lo_val_i (cfg_q.lo_val),
        .result_o (op_result),
        .pass_o   (op_pass)
    );

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        word_addr_d = word_addr_q;
        pix_addr_d  = pix_addr_q;
        k_d         = k_q;
        word_d      = word_q;
        dst_di_d    = dst_di_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go_accept) begin
                    state_d     = ST_READ;
                    cfg_d       = '{mode: mode_t'(Mode), th_lo: ThLo, th_hi: ThHi,
                                    hi_val: HiVal, lo_val: LoVal};
                    word_addr_d = '0;
                    pix_addr_d  = '0;
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                word_d  = Src_Do;
                k_d     = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                dst_di_d = op_result;
                word_d   = word_q >> PIX_W;
                if (pix_addr_q == LAST_PIX) begin
                    state_d = ST_DONE;
                end else begin
                    pix_addr_d = pix_addr_q + 1'b1;
                    if (k_q == LAST_K) begin
                        word_addr_d = word_addr_q + 1'b1;
                        state_d     = ST_READ;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            word_addr_q <= '0;
            pix_addr_q  <= '0;
            k_q         <= '0;
            word_q      <= '0;
            dst_di_q    <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            word_addr_q <= word_addr_d;
            pix_addr_q  <= pix_addr_d;
            k_q         <= k_d;
            word_q      <= word_d;
            dst_di_q    <= dst_di_d;
        end
    end

    assign Src_En   = (state_q == ST_READ);
    assign Src_Addr = word_addr_q;
    assign Dst_En   = (state_q == ST_WRITE);
    assign Dst_We   = (state_q == ST_WRITE);
    assign Dst_Addr = pix_addr_q;
    assign Dst_Di   = Dst_We ? op_result : dst_di_q;
    assign Done     = (state_q == ST_DONE);
    assign Busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef THRESH_STATS_EN
    logic [DST_AW:0] hi_cnt_q, hi_cnt_d;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        if (go_accept)
            hi_cnt_d = '0;
        else if ((state_q == ST_WRITE) && op_pass)
            hi_cnt_d = hi_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) hi_cnt_q <= '0;
        else     hi_cnt_q <= hi_cnt_d;
    end

    assign HiCount = hi_cnt_q;
`else
    assign HiCount = '0;
`endif

endmodule
